// File: rtl/rf_wr_arbiter_if.sv
// rf_wr_arbiter_if: writeback, MDU result and register-file write port bundle; slave = arbiter side, master = driver side
interface rf_wr_arbiter_if #(parameter int XLEN = 64);
  logic            wb_valid_i;
  logic            wb_rd_wren_i;
  logic [4:0]      wb_rd_idx_i;
  logic [XLEN-1:0] wb_rd_data_i;
  logic            wb_stall_o;
  logic            mdu_valid_i;
  logic            mdu_ready_o;
  logic [4:0]      mdu_rd_idx_i;
  logic [XLEN-1:0] mdu_rd_data_i;
  logic            rf_wren_o;
  logic [4:0]      rf_idx_o;
  logic [XLEN-1:0] rf_data_o;
  logic            mdu_pending_o;
  modport slave (
    input  wb_valid_i, wb_rd_wren_i, wb_rd_idx_i, wb_rd_data_i,
    input  mdu_valid_i, mdu_rd_idx_i, mdu_rd_data_i,
    output wb_stall_o, mdu_ready_o, rf_wren_o, rf_idx_o, rf_data_o, mdu_pending_o
  );
  modport master (
    output wb_valid_i, wb_rd_wren_i, wb_rd_idx_i, wb_rd_data_i,
    output mdu_valid_i, mdu_rd_idx_i, mdu_rd_data_i,
    input  wb_stall_o, mdu_ready_o, rf_wren_o, rf_idx_o, rf_data_o, mdu_pending_o
  );
endinterface

// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter: shares the register-file write port between WB and a 2-entry MDU result buffer (clk, rst_n sync active-low, bus = rf_wr_arbiter_if.slave)
module rf_wr_arbiter #(
  parameter int XLEN         = 64,
  parameter int STARVE_LIMIT = 4
) (
  input logic            clk,
  input logic            rst_n,
  rf_wr_arbiter_if.slave bus
);
  typedef enum logic {WB_PRI, MDU_FORCE} state_t;
  state_t          state, state_nx;
  logic [1:0]      live;
  logic [4:0]      idx [2];
  logic [XLEN-1:0] data [2];
  logic            wp, rp;
  logic [1:0]      cnt, cnt_nx;
  logic [3:0]      starve;
  logic            wb_req, head_valid, head_live, force_pop, mdu_grant, wb_grant, push, pop, push_live;
  always_comb begin
    wb_req     = bus.wb_valid_i & bus.wb_rd_wren_i & (bus.wb_rd_idx_i != 5'd0);
    head_valid = cnt != 2'd0;
    head_live  = live[rp];
    force_pop  = head_live & (state == MDU_FORCE | cnt == 2'd2 | starve == 4'(STARVE_LIMIT));
    mdu_grant  = head_live & (force_pop | ~wb_req);
    wb_grant   = wb_req & ~mdu_grant;
    pop        = head_valid & (mdu_grant | ~head_live);
    push       = bus.mdu_valid_i & bus.mdu_ready_o;
    push_live  = (bus.mdu_rd_idx_i != 5'd0) & ~(wb_grant & bus.mdu_rd_idx_i == bus.wb_rd_idx_i);
    cnt_nx     = cnt + {1'b0, push} - {1'b0, pop};
    state_nx   = state == WB_PRI ? (force_pop ? MDU_FORCE : WB_PRI)
               : ((cnt_nx == 2'd2 || (head_valid && !head_live)) ? MDU_FORCE : WB_PRI);
  end
  assign bus.wb_stall_o    = wb_req & mdu_grant;
  assign bus.mdu_ready_o   = cnt != 2'd2;
  assign bus.mdu_pending_o = |live;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= WB_PRI;
      cnt           <= 2'd0;
      wp            <= 1'b0;
      rp            <= 1'b0;
      starve        <= 4'd0;
      live          <= 2'b00;
      bus.rf_wren_o <= 1'b0;
      bus.rf_idx_o  <= 5'd0;
      bus.rf_data_o <= '0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      wp     <= wp ^ push;
      rp     <= rp ^ pop;
      starve <= pop ? 4'd0 : (head_live && starve != 4'(STARVE_LIMIT)) ? starve + 4'd1 : starve;
      for (int i = 0; i < 2; i++)
        if (wb_grant && idx[i] == bus.wb_rd_idx_i) live[i] <= 1'b0;
      if (pop) live[rp] <= 1'b0;
      if (push) begin
        live[wp] <= push_live;
        idx[wp]  <= bus.mdu_rd_idx_i;
        data[wp] <= bus.mdu_rd_data_i;
      end
      bus.rf_wren_o <= wb_grant | mdu_grant;
      if (wb_grant | mdu_grant) begin
        bus.rf_idx_o  <= wb_grant ? bus.wb_rd_idx_i : idx[rp];
        bus.rf_data_o <= wb_grant ? bus.wb_rd_data_i : data[rp];
      end
    end
  end
endmodule

// File: tb/tb_rf_wr_arbiter.sv
// tb_rf_wr_arbiter: table-driven directed check of rf_wr_arbiter plus a reset-mid-drain sequence
module tb_rf_wr_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  rf_wr_arbiter_if #(.XLEN(64)) bus();
  rf_wr_arbiter #(.XLEN(64), .STARVE_LIMIT(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  typedef struct {
    logic wv, ww; logic [4:0] wi; logic [63:0] wd;
    logic mv; logic [4:0] mi; logic [63:0] md;
    logic st, rdy, pd, rw, ci; logic [4:0] ri; logic [63:0] rd;
  } vec_t;
  vec_t  tbl[$];
  int    n_chk = 0, n_fail = 0;
  string tag;
  function automatic vec_t v(input logic wv, ww, input logic [4:0] wi, input logic [63:0] wd,
                             input logic mv, input logic [4:0] mi, input logic [63:0] md,
                             input logic st, rdy, pd, rw, ci, input logic [4:0] ri, input logic [63:0] rd);
    vec_t t;
    t.wv = wv; t.ww = ww; t.wi = wi; t.wd = wd; t.mv = mv; t.mi = mi; t.md = md;
    t.st = st; t.rdy = rdy; t.pd = pd; t.rw = rw; t.ci = ci; t.ri = ri; t.rd = rd;
    return t;
  endfunction
  task automatic drive(input logic wv, ww, input logic [4:0] wi, input logic [63:0] wd,
                       input logic mv, input logic [4:0] mi, input logic [63:0] md);
    bus.wb_valid_i = wv; bus.wb_rd_wren_i = ww; bus.wb_rd_idx_i = wi; bus.wb_rd_data_i = wd;
    bus.mdu_valid_i = mv; bus.mdu_rd_idx_i = mi; bus.mdu_rd_data_i = md;
  endtask
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s %s: got %0h expected %0h", tag, name, act, exp);
    end
  endtask
  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);
    // WB-only stream
    tbl.push_back(v(0,0,0,0,       0,0,0,       0,1,0,0,0,0,0));
    tbl.push_back(v(1,1,1,'h11,    0,0,0,       0,1,0,0,0,0,0));
    tbl.push_back(v(1,1,2,'h22,    0,0,0,       0,1,0,1,1,1,'h11));
    tbl.push_back(v(0,0,0,0,       0,0,0,       0,1,0,1,1,2,'h22));
    tbl.push_back(v(0,0,0,0,       0,0,0,       0,1,0,0,1,2,'h22));
    // idle drain
    tbl.push_back(v(0,0,0,0,       1,5,'hAB,    0,1,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,       0,0,0,       0,1,1,0,0,0,0));
    tbl.push_back(v(0,0,0,0,       0,0,0,       0,1,0,1,1,5,'hAB));
    tbl.push_back(v(0,0,0,0,       0,0,0,       0,1,0,0,0,0,0));
    // starvation: 4 WB grants, then one forced x6 write
    tbl.push_back(v(1,1,7,'h77,    1,6,'h66,    0,1,0,0,0,0,0));
    tbl.push_back(v(1,1,7,'h77,    0,0,0,       0,1,1,1,1,7,'h77));
    tbl.push_back(v(1,1,7,'h77,    0,0,0,       0,1,1,1,1,7,'h77));
    tbl.push_back(v(1,1,7,'h77,    0,0,0,       0,1,1,1,1,7,'h77));
    tbl.push_back(v(1,1,7,'h77,    0,0,0,       0,1,1,1,1,7,'h77));
    tbl.push_back(v(1,1,7,'h77,    0,0,0,       1,1,1,1,1,7,'h77));
    tbl.push_back(v(1,1,7,'h77,    0,0,0,       0,1,0,1,1,6,'h66));
    tbl.push_back(v(0,0,0,0,       0,0,0,       0,1,0,1,1,7,'h77));
    tbl.push_back(v(0,0,0,0,       0,0,0,       0,1,0,0,0,0,0));
    // full buffer: x11 offered while full must be rejected
    tbl.push_back(v(1,1,7,'h77,    1,8,'h88,    0,1,0,0,0,0,0));
    tbl.push_back(v(1,1,7,'h77,    1,9,'h99,    0,1,1,1,1,7,'h77));
    tbl.push_back(v(1,1,7,'h77,    1,11,'hBB,   1,0,1,1,1,7,'h77));
    tbl.push_back(v(1,1,7,'h77,    0,0,0,       1,1,1,1,1,8,'h88));
    tbl.push_back(v(1,1,7,'h77,    0,0,0,       0,1,0,1,1,9,'h99));
    tbl.push_back(v(0,0,0,0,       0,0,0,       0,1,0,1,1,7,'h77));
    tbl.push_back(v(0,0,0,0,       0,0,0,       0,1,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,       0,0,0,       0,1,0,0,0,0,0));
    // WAW kill, WB after the push; dead head does not block WB x3
    tbl.push_back(v(0,0,0,0,       1,10,'h1,    0,1,0,0,0,0,0));
    tbl.push_back(v(1,1,10,'h2,    0,0,0,       0,1,1,0,0,0,0));
    tbl.push_back(v(1,1,3,'h33,    0,0,0,       0,1,0,1,1,10,'h2));
    tbl.push_back(v(0,0,0,0,       0,0,0,       0,1,0,1,1,3,'h33));
    // WAW kill, push in the same cycle as the WB grant
    tbl.push_back(v(1,1,10,'h3,    1,10,'h1,    0,1,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,       0,0,0,       0,1,0,1,1,10,'h3));
    tbl.push_back(v(0,0,0,0,       0,0,0,       0,1,0,0,0,0,0));
    // x0 on both sides: no write, no pending, outputs hold
    tbl.push_back(v(1,1,0,'h55,    1,0,'h12,    0,1,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,       0,0,0,       0,1,0,0,1,10,'h3));
    tbl.push_back(v(0,0,0,0,       0,0,0,       0,1,0,0,1,10,'h3));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    foreach (tbl[i]) begin
      drive(tbl[i].wv, tbl[i].ww, tbl[i].wi, tbl[i].wd, tbl[i].mv, tbl[i].mi, tbl[i].md);
      tag = $sformatf("row%0d", i);
      @(negedge clk);
      chk("wb_stall", bus.wb_stall_o, tbl[i].st);
      chk("mdu_ready", bus.mdu_ready_o, tbl[i].rdy);
      chk("mdu_pending", bus.mdu_pending_o, tbl[i].pd);
      chk("rf_wren", bus.rf_wren_o, tbl[i].rw);
      if (tbl[i].ci) begin
        chk("rf_idx", bus.rf_idx_o, tbl[i].ri);
        chk("rf_data", bus.rf_data_o, tbl[i].rd);
      end
      @(posedge clk);
      #1;
    end
    // reset mid-drain with two buffered entries
    tag = "rst";
    drive(1, 1, 7, 'h77, 1, 8, 'h88);
    @(posedge clk); #1;
    drive(1, 1, 7, 'h77, 1, 9, 'h99);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("full_before_rst", bus.mdu_ready_o, 1'b0);
    chk("pending_before_rst", bus.mdu_pending_o, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(1, 1, 4, 'h44, 0, 0, 0);
    @(negedge clk);
    chk("ready_after_rst", bus.mdu_ready_o, 1'b1);
    chk("pending_after_rst", bus.mdu_pending_o, 1'b0);
    chk("wren_after_rst", bus.rf_wren_o, 1'b0);
    chk("idx_after_rst", bus.rf_idx_o, 5'd0);
    chk("stall_after_rst", bus.wb_stall_o, 1'b0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("wb_after_rst_wren", bus.rf_wren_o, 1'b1);
    chk("wb_after_rst_idx", bus.rf_idx_o, 5'd4);
    chk("wb_after_rst_data", bus.rf_data_o, 64'h44);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      tag = $sformatf("rst_idle%0d", k);
      chk("no_drain_wren", bus.rf_wren_o, 1'b0);
      chk("no_drain_pending", bus.mdu_pending_o, 1'b0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rf_wr_arbiter.md
# rf_wr_arbiter

Arbiter and sequencer for the single integer register-file write port. It shares that port between the in-order writeback stage and a multi-cycle MUL/DIV unit (MDU). MDU results go into a 2-entry result buffer and drain when the port is free. A starvation counter and a buffer-full rule force MDU drains by stalling writeback. The block sits between the WB stage outputs and the register file.

## Interface
- XLEN, 64, data width
- STARVE_LIMIT, 4, consecutive lost cycles before the MDU head entry is forced (1..15)

- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- wb_valid_i  in  1  WB stage holds a valid instruction
- wb_rd_wren_i  in  1  WB instruction writes rd
- wb_rd_idx_i  in  5  WB destination register
- wb_rd_data_i  in  XLEN  WB write data
- wb_stall_o  out  1  WB write not granted this cycle; WB holds its inputs stable
- mdu_valid_i  in  1  MDU result available
- mdu_ready_o  out  1  buffer can accept a result
- mdu_rd_idx_i  in  5  MDU destination register
- mdu_rd_data_i  in  XLEN  MDU result
- rf_wren_o  out  1  register-file write enable (registered)
- rf_idx_o  out  5  register-file write index (registered)
- rf_data_o  out  XLEN  register-file write data (registered)
- mdu_pending_o  out  1  at least one live entry is in the buffer

## Operation
- WB request: wb_valid_i & wb_rd_wren_i & (wb_rd_idx_i != 0). Requests to x0 are dropped and never stall.
- MDU push: mdu_valid_i & mdu_ready_o. mdu_ready_o = (count < 2).
  - Results to x0 are accepted but stored with live = 0.
- Buffer: 2-entry FIFO. Each entry holds {live, idx, data}. count is 0..2. Pointers are 1 bit and wrap.
- Arbitration state machine, 2 states:
  - WB_PRI (reset state): a WB request wins. The head entry is granted only when there is no WB request.
  - MDU_FORCE: a live head entry wins. A WB request in the same cycle gets wb_stall_o = 1.
  - WB_PRI → MDU_FORCE when count == 2, or when starve_cnt == STARVE_LIMIT, with a live head entry in either case.
  - MDU_FORCE → WB_PRI after the forced pop, unless count is still 2 after that pop's push accounting.
  - The next-state decision is combinational from registered state, so forcing takes effect in the same cycle the condition is seen.
- Pop: happens when the head is granted, or when the head is dead (live = 0).
  - A dead head pops in one cycle and uses no write port.
  - A dead head does not block a WB grant in that cycle.
- WAW kill: when a WB write is granted, every buffered entry with a matching idx has live cleared.
  - A same-cycle push with a matching idx is stored with live = 0. WB is the architecturally younger write.
- starve_cnt (4 bits):
  - Increments each cycle a live head exists and is not granted.
  - Clears on pop.
  - Saturates at STARVE_LIMIT.
- Push and pop in the same cycle leave count unchanged. A push is accepted in the same cycle as a pop only if count < 2 before that pop (ready is not combinationally freed).
- mdu_pending_o = OR of the live bits of valid entries.

## Timing
- Reset values, applied while rst_n is low at a clk edge:
  - State = WB_PRI; count = 0; pointers = 0; starve_cnt = 0; all live bits = 0.
  - rf_wren_o = 0, rf_idx_o = 0, rf_data_o = 0.
  - mdu_ready_o = 1; mdu_pending_o = 0; wb_stall_o = 0.
- Reset mid-operation discards all buffered results. The core flushes MDU state on the same reset.
- Grant in cycle t → rf_wren_o/rf_idx_o/rf_data_o valid in cycle t+1, for exactly one cycle.
- A cycle with no grant → rf_wren_o = 0 in the next cycle. rf_idx_o and rf_data_o hold their last values.
- MDU push in cycle t → the entry is at the head no earlier than t+1 → the earliest write appears at t+2. There is no bypass.
- wb_stall_o is combinational from the current inputs and registered state. It is asserted only when a WB request exists and MDU wins.

## Test plan
- WB-only stream: WB writes x1=0x11, x2=0x22 in consecutive cycles → rf_wren_o high for 2 cycles, one cycle later, with matching idx/data; wb_stall_o stays 0.
- Idle drain: MDU pushes x5=0xAB with no WB traffic → rf write x5=0xAB exactly 2 cycles after the push; mdu_pending_o returns to 0.
- Starvation, STARVE_LIMIT = 4: one MDU entry x6 plus continuous WB writes to x7 → WB is granted 4 cycles, then wb_stall_o = 1 for one cycle and x6 is written; WB resumes the cycle after.
- Full buffer: 2 pushes (x8, x9) during continuous WB writes → mdu_ready_o = 0; MDU_FORCE is entered; x8 then x9 are written in consecutive cycles with WB stalled in both; mdu_ready_o returns to 1.
- WAW kill: MDU x10=0x1 is buffered, then WB writes x10=0x2 → only the 0x2 write reaches the register file; the dead entry pops with no write and no stall. Repeat with the push in the same cycle as the WB grant → same result.
- Reset mid-drain: 2 entries are buffered and rst_n is pulled low for 1 cycle → no further rf writes; count = 0, mdu_ready_o = 1 and rf_wren_o = 0 in the cycle after reset.
